// File: rtl/simple_log_udp_noc_write_if.sv
// Bus bundle between the traced client, the log writer and the log RAM write port.
// The slave modport is the log writer's view; the master modport is its environment.
interface simple_log_udp_noc_write_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int TS_W   = 32,
    parameter int DROP_W = 16
);
    logic                     log_in_val;
    logic [DATA_W-1:0]        log_in_data;
    logic                     log_in_rdy;
    logic                     log_enable;
    logic                     log_clear;
    logic                     log_wr_req_val;
    logic [ADDR_W-1:0]        log_wr_req_addr;
    logic [TS_W+DATA_W-1:0]   log_wr_req_data;
    logic                     log_wr_req_rdy;
    logic [ADDR_W-1:0]        curr_wr_addr;
    logic                     has_wrapped;
    logic [DROP_W-1:0]        log_drop_cnt;

    modport slave (
        input  log_in_val, log_in_data, log_enable, log_clear, log_wr_req_rdy,
        output log_in_rdy, log_wr_req_val, log_wr_req_addr, log_wr_req_data,
               curr_wr_addr, has_wrapped, log_drop_cnt
    );

    modport master (
        output log_in_val, log_in_data, log_enable, log_clear, log_wr_req_rdy,
        input  log_in_rdy, log_wr_req_val, log_wr_req_addr, log_wr_req_data,
               curr_wr_addr, has_wrapped, log_drop_cnt
    );
endinterface

// File: rtl/simple_log_udp_noc_write.sv
// Producer side of the simple log: timestamps client entries and writes them into the
// log RAM as a circular buffer, publishing the write pointer and wrap flag to the reader.
module simple_log_udp_noc_write #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 64,
    parameter int TS_W         = 32,
    parameter int STOP_ON_FULL = 0,
    parameter int DROP_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    simple_log_udp_noc_write_if.slave   io_bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {ST_EMPTY, ST_PENDING} state_t;

    state_t                   r_state;
    logic                     r_active;
    logic                     r_frozen;
    logic                     r_wrapped;
    logic [ADDR_W-1:0]        r_wr_addr;
    logic [TS_W-1:0]          r_ts;
    logic [TS_W+DATA_W-1:0]   r_entry;
    logic [DROP_W-1:0]        r_drop;

    logic w_hs;
    logic w_last_hs;
    logic w_freeze_now;
    logic w_rdy;
    logic w_accept;
    logic w_store;
    logic w_discard;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Handshake decode: RAM write completion, freeze point, and client acceptance.
    // An entry arriving in the same cycle as the final write of a stop-on-full log is
    // discarded, because the log freezes before it could ever be written.
    always_comb begin
        w_hs         = (r_state == ST_PENDING) && io_bus.log_wr_req_rdy;
        w_last_hs    = w_hs && (r_wr_addr == LAST_ADDR);
        w_freeze_now = r_frozen || ((STOP_ON_FULL != 0) && w_last_hs);
        w_rdy        = r_active && !io_bus.log_clear &&
                       (r_frozen || !io_bus.log_enable || (r_state == ST_EMPTY) || w_hs);
        w_accept     = io_bus.log_in_val && w_rdy;
        w_store      = w_accept && io_bus.log_enable && !w_freeze_now;
        w_discard    = w_accept && !w_store;
    end

    // Free-running timestamp; keeps counting through disable and clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ts <= '0;
        else     r_ts <= r_ts + 1'b1;
    end

    // Holds log_in_rdy low while in reset and releases it one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_active <= 1'b0;
        else     r_active <= 1'b1;
    end

    // Holding-register FSM, write pointer, wrap/freeze flags and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_wr_addr <= '0;
            r_wrapped <= 1'b0;
            r_frozen  <= 1'b0;
            r_drop    <= '0;
        end else if (io_bus.log_clear) begin
            r_state   <= ST_EMPTY;
            r_wr_addr <= '0;
            r_wrapped <= 1'b0;
            r_frozen  <= 1'b0;
            r_drop    <= '0;
        end else begin
            if (w_hs)      r_wr_addr <= r_wr_addr + 1'b1;
            if (w_last_hs) r_wrapped <= 1'b1;
            r_frozen <= w_freeze_now;
            if (w_store)   r_state <= ST_PENDING;
            else if (w_hs) r_state <= ST_EMPTY;
            if (w_discard) r_drop <= sat_inc(r_drop);
        end
    end

    // Captures {timestamp, payload}; only loads on acceptance so it stays stable while pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_entry <= '0;
        else if (w_store) r_entry <= {r_ts, io_bus.log_in_data};
    end

    assign io_bus.log_in_rdy      = w_rdy;
    assign io_bus.log_wr_req_val  = (r_state == ST_PENDING);
    assign io_bus.log_wr_req_addr = r_wr_addr;
    assign io_bus.log_wr_req_data = r_entry;
    assign io_bus.curr_wr_addr    = r_wr_addr;
    assign io_bus.has_wrapped     = r_wrapped;
    assign io_bus.log_drop_cnt    = r_drop;
endmodule

// File: tb/tb_simple_log_udp_noc_write.sv
// Bench for simple_log_udp_noc_write: two instances (overwrite and stop-on-full) share
// one stimulus stream; a write-count based reference model predicts every output.
module tb_simple_log_udp_noc_write;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;
    localparam int TS_W   = 16;
    localparam int DROP_W = 4;
    localparam int DEPTH  = 8;
    localparam int EW     = TS_W + DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              t_val  = 1'b0;
    logic [DATA_W-1:0] t_data = '0;
    logic              t_en   = 1'b1;
    logic              t_clr  = 1'b0;
    logic              t_wrdy = 1'b1;

    simple_log_udp_noc_write_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TS_W(TS_W), .DROP_W(DROP_W)) b0 ();
    simple_log_udp_noc_write_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TS_W(TS_W), .DROP_W(DROP_W)) b1 ();

    assign b0.log_in_val = t_val;   assign b1.log_in_val = t_val;
    assign b0.log_in_data = t_data; assign b1.log_in_data = t_data;
    assign b0.log_enable = t_en;    assign b1.log_enable = t_en;
    assign b0.log_clear = t_clr;    assign b1.log_clear = t_clr;
    assign b0.log_wr_req_rdy = t_wrdy; assign b1.log_wr_req_rdy = t_wrdy;

    simple_log_udp_noc_write #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TS_W(TS_W),
        .STOP_ON_FULL(0), .DROP_W(DROP_W)) dut0 (.clk(clk), .rst(rst), .io_bus(b0));
    simple_log_udp_noc_write #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TS_W(TS_W),
        .STOP_ON_FULL(1), .DROP_W(DROP_W)) dut1 (.clk(clk), .rst(rst), .io_bus(b1));

    logic [1:0]        o_rdy, o_val, o_wrap;
    logic [ADDR_W-1:0] o_addr [2];
    logic [ADDR_W-1:0] o_curr [2];
    logic [EW-1:0]     o_data [2];
    logic [DROP_W-1:0] o_drop [2];
    assign o_rdy  = {b1.log_in_rdy, b0.log_in_rdy};
    assign o_val  = {b1.log_wr_req_val, b0.log_wr_req_val};
    assign o_wrap = {b1.has_wrapped, b0.has_wrapped};
    assign o_addr[0] = b0.log_wr_req_addr; assign o_addr[1] = b1.log_wr_req_addr;
    assign o_curr[0] = b0.curr_wr_addr;    assign o_curr[1] = b1.curr_wr_addr;
    assign o_data[0] = b0.log_wr_req_data; assign o_data[1] = b1.log_wr_req_data;
    assign o_drop[0] = b0.log_drop_cnt;    assign o_drop[1] = b1.log_drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: total writes since clear determine pointer/wrap/freeze;
    // the holding slot is a 0/1-deep queue of {timestamp, payload}.
    int                m_nwr  [2];
    logic              m_full [2];
    logic [EW-1:0]     m_ent  [2];
    logic [DROP_W-1:0] m_drop [2];
    logic              m_alive;
    logic [TS_W-1:0]   m_ts;
    int                nw_obs [2];

    typedef struct {
        logic              val;
        logic              en;
        logic              clr;
        logic              wrdy;
        logic [DATA_W-1:0] data;
        logic              e_wval;
        int                e_addr;
        logic [DATA_W-1:0] e_pay;
        int                e_curr;
        logic              e_rdy;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_nwr[d] = 0; m_full[d] = 1'b0; m_ent[d] = '0; m_drop[d] = '0;
        end
        m_alive = 1'b0;
        m_ts    = '0;
    endtask

    // Called just after a falling edge with inputs driven; checks, then advances one clock.
    task automatic cycle();
        int                nn [2];
        logic              nf [2];
        logic [EW-1:0]     ne [2];
        logic [DROP_W-1:0] nd [2];
        bit frz, hs, er, acc, st;
        #1;
        for (int d = 0; d < 2; d++) begin
            frz = (d == 1) && (m_nwr[d] >= DEPTH);
            hs  = m_full[d] && t_wrdy;
            er  = m_alive && !t_clr && (frz || !t_en || !m_full[d] || hs);
            chk($sformatf("d%0d rdy", d), 64'(o_rdy[d]), 64'(er));
            chk($sformatf("d%0d wr_val", d), 64'(o_val[d]), 64'(m_full[d]));
            chk($sformatf("d%0d curr", d), 64'(o_curr[d]), 64'(m_nwr[d] % DEPTH));
            chk($sformatf("d%0d wrapped", d), 64'(o_wrap[d]), 64'(m_nwr[d] >= DEPTH));
            chk($sformatf("d%0d drop", d), 64'(o_drop[d]), 64'(m_drop[d]));
            if (m_full[d]) begin
                chk($sformatf("d%0d wr_addr", d), 64'(o_addr[d]), 64'(m_nwr[d] % DEPTH));
                chk($sformatf("d%0d wr_data", d), 64'(o_data[d]), 64'(m_ent[d]));
            end
            if (o_val[d] && t_wrdy) nw_obs[d]++;
            acc = t_val && er;
            st  = acc && t_en && !((d == 1) && ((m_nwr[d] + (hs ? 1 : 0)) >= DEPTH));
            nn[d] = m_nwr[d]; nf[d] = m_full[d]; ne[d] = m_ent[d]; nd[d] = m_drop[d];
            if (t_clr) begin
                nn[d] = 0; nf[d] = 1'b0; nd[d] = '0;
            end else begin
                if (hs) nn[d] = m_nwr[d] + 1;
                if (st) begin
                    nf[d] = 1'b1; ne[d] = {m_ts, t_data};
                end else if (hs) begin
                    nf[d] = 1'b0;
                end
                if (acc && !st) nd[d] = (m_drop[d] == '1) ? m_drop[d] : m_drop[d] + 1'b1;
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_nwr[d] = nn[d]; m_full[d] = nf[d]; m_ent[d] = ne[d]; m_drop[d] = nd[d];
        end
        m_ts    = m_ts + 1'b1;
        m_alive = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        t_val = 1'b0; t_clr = 1'b1;
        cycle();
        t_clr = 1'b0;
    endtask

    initial begin
        int w0;
        // Back-to-back writes on an 8-deep log: addresses 0..4 on consecutive cycles.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hA000, 1'b0, 0, 16'h0000, 0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hA001, 1'b1, 0, 16'hA000, 0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hA002, 1'b1, 1, 16'hA001, 1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hA003, 1'b1, 2, 16'hA002, 2, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hA004, 1'b1, 3, 16'hA003, 3, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 4, 16'hA004, 4, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 0, 16'h0000, 5, 1'b1};

        model_reset();
        nw_obs[0] = 0; nw_obs[1] = 0;

        // Reset state
        #1;
        chk("reset rdy", 64'(b0.log_in_rdy), 64'(0));
        chk("reset wr_val", 64'(b0.log_wr_req_val), 64'(0));
        chk("reset curr", 64'(b0.curr_wr_addr), 64'(0));
        chk("reset data", 64'(b0.log_wr_req_data), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cycle();

        // Table-driven back-to-back sequence on the overwrite instance
        for (int i = 0; i < 7; i++) begin
            t_val = tbl[i].val; t_en = tbl[i].en; t_clr = tbl[i].clr;
            t_wrdy = tbl[i].wrdy; t_data = tbl[i].data;
            #1;
            chk($sformatf("tbl%0d wr_val", i), 64'(o_val[0]), 64'(tbl[i].e_wval));
            if (tbl[i].e_wval) begin
                chk($sformatf("tbl%0d wr_addr", i), 64'(o_addr[0]), 64'(tbl[i].e_addr));
                chk($sformatf("tbl%0d payload", i), 64'(o_data[0][DATA_W-1:0]), 64'(tbl[i].e_pay));
            end
            chk($sformatf("tbl%0d curr", i), 64'(o_curr[0]), 64'(tbl[i].e_curr));
            chk($sformatf("tbl%0d rdy", i), 64'(o_rdy[0]), 64'(tbl[i].e_rdy));
            cycle();
        end
        chk("t1 wrapped", 64'(b0.has_wrapped), 64'(0));

        // Ten entries into an 8-deep log: overwrite vs stop-on-full
        pulse_clear();
        nw_obs[0] = 0; nw_obs[1] = 0;
        t_wrdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            t_val = 1'b1; t_data = DATA_W'(16'hB000 + i);
            cycle();
        end
        t_val = 1'b0;
        repeat (3) cycle();
        chk("t2 writes", 64'(nw_obs[0]), 64'(10));
        chk("t2 curr", 64'(b0.curr_wr_addr), 64'(2));
        chk("t2 wrapped", 64'(b0.has_wrapped), 64'(1));
        chk("t3 writes", 64'(nw_obs[1]), 64'(8));
        chk("t3 curr", 64'(b1.curr_wr_addr), 64'(0));
        chk("t3 wrapped", 64'(b1.has_wrapped), 64'(1));
        chk("t3 drop", 64'(b1.log_drop_cnt), 64'(2));

        // RAM backpressure with an entry pending
        pulse_clear();
        w0 = nw_obs[0];
        t_wrdy = 1'b0; t_val = 1'b1; t_data = 16'hC000;
        cycle();
        t_data = 16'hC001;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4 hold val", 64'(b0.log_wr_req_val), 64'(1));
            chk("t4 hold addr", 64'(b0.log_wr_req_addr), 64'(0));
            chk("t4 hold payload", 64'(b0.log_wr_req_data[DATA_W-1:0]), 64'(16'hC000));
            chk("t4 rdy low", 64'(b0.log_in_rdy), 64'(0));
            cycle();
        end
        chk("t4 no writes", 64'(nw_obs[0] - w0), 64'(0));
        t_wrdy = 1'b1;
        cycle();
        t_val = 1'b0;
        repeat (2) cycle();
        chk("t4 curr", 64'(b0.curr_wr_addr), 64'(2));

        // Logging disabled: entries dropped, counter saturates, clear empties it
        pulse_clear();
        w0 = nw_obs[0];
        t_en = 1'b0; t_val = 1'b1;
        repeat (3) cycle();
        t_val = 1'b0;
        cycle();
        chk("t5 drop", 64'(b0.log_drop_cnt), 64'(3));
        chk("t5 no writes", 64'(nw_obs[0] - w0), 64'(0));
        t_val = 1'b1;
        repeat (20) cycle();
        t_val = 1'b0;
        cycle();
        chk("t5 drop sat", 64'(b0.log_drop_cnt), 64'(15));
        pulse_clear();
        chk("t5 clr drop", 64'(b0.log_drop_cnt), 64'(0));
        chk("t5 clr curr", 64'(b0.curr_wr_addr), 64'(0));
        chk("t5 clr wrapped", 64'(b0.has_wrapped), 64'(0));
        t_en = 1'b1;

        // Clear coincident with the handshake at address 6
        t_wrdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            t_val = 1'b1; t_data = DATA_W'(16'hD000 + i);
            cycle();
        end
        t_val = 1'b0; t_clr = 1'b1;
        #1;
        chk("t6 pend val", 64'(b0.log_wr_req_val), 64'(1));
        chk("t6 pend addr", 64'(b0.log_wr_req_addr), 64'(6));
        cycle();
        t_clr = 1'b0;
        chk("t6 curr after clr", 64'(b0.curr_wr_addr), 64'(0));

        // Asynchronous reset while an entry is pending
        t_wrdy = 1'b0; t_val = 1'b1; t_data = 16'hE000;
        cycle();
        t_val = 1'b0;
        chk("t6 pending before rst", 64'(b0.log_wr_req_val), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("t6 async val d0", 64'(b0.log_wr_req_val), 64'(0));
        chk("t6 async val d1", 64'(b1.log_wr_req_val), 64'(0));
        chk("t6 async rdy", 64'(b0.log_in_rdy), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        t_wrdy = 1'b1;
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            t_val  = ($urandom_range(0, 3) != 0);
            t_en   = ($urandom_range(0, 7) != 0);
            t_wrdy = ($urandom_range(0, 3) != 0);
            t_clr  = ($urandom_range(0, 63) == 0);
            t_data = DATA_W'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
